// File: rtl/knn_drv_pkg.sv
// Shared types and constants for the KNN peripheral bus driver.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package knn_drv_pkg;

  // Top-level sequencing states, in run order.
  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HI,
    S_RST_LO,
    S_WR_EN,
    S_WR_A,
    S_WAIT_TP,
    S_WR_B,
    S_WR_LBL,
    S_RD_INFO,
    S_DONE
  } drv_state_t;

  // Default peripheral register word addresses.
  localparam int DEF_A_RESET  = 0;
  localparam int DEF_A_ENABLE = 1;
  localparam int DEF_A_A      = 2;
  localparam int DEF_A_B      = 3;
  localparam int DEF_A_LABEL  = 4;
  localparam int DEF_A_INFO0  = 5;

  // Index width for n items: clog2(n), never less than one bit.
  function automatic int width_idx(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/knn_drv_xact.sv
// Single native-bus transaction engine: one request -> one valid/ready exchange.
// Latency: m_valid rises the cycle after req is seen idle; ack is combinational with m_ready.
// Backpressure: holds m_valid and payload until m_ready; optional watchdog aborts the request.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req, addr, wdata, we    request from the sequencer (level, held until ack/timeout)
//   ack                     completion strobe (m_valid & m_ready)
//   rdata_q                 read data captured on completion of a read
//   timeout                 watchdog expiry strobe (KNN_DRV_TIMEOUT_EN only, else 0)
//   m_*                     native master port
module knn_drv_xact #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                we,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata_q,
  output logic                timeout,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  // m_ready outside a live request is meaningless and is masked here.
  assign ack = m_valid & m_ready;

`ifdef KNN_DRV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  // Fires on the TIMEOUT-th stalled cycle, so m_valid is high exactly TIMEOUT cycles.
  assign timeout = m_valid & ~m_ready & (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (!m_valid) begin
      wd_cnt <= '0;
    end else if (!m_ready) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_lim = TIMEOUT;
  assign timeout = 1'b0;
`endif

  // A new request is only taken while m_valid is low, which guarantees the
  // one idle cycle after every completion and a stable payload while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      rdata_q   <= '0;
    end else if (m_valid) begin
      if (m_ready || timeout) begin
        m_valid <= 1'b0;
      end
      if (m_ready && (m_wstrb == '0)) begin
        rdata_q <= m_rdata;
      end
    end else if (req) begin
      m_valid   <= 1'b1;
      m_address <= addr;
      m_wdata   <= wdata;
      m_wstrb   <= {(DATA_W/8){we}};
    end
  end

endmodule

// File: rtl/knn_bus_driver.sv
// Native-bus initiator that programs the KNN peripheral and streams back neighbour labels.
// Latency: 3 cycles per bus transaction with a 1-cycle slave; done 2 cycles after last result.
// Backpressure: stalls on m_ready per transaction; tp_ready only in WAIT_TP; no res backpressure.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, test_pt                     run request and test point (sampled in IDLE)
//   tp_valid/tp_ready, tp_b, tp_label, tp_last   training-point stream
//   m_valid, m_address, m_wdata, m_wstrb, m_rdata, m_ready   native master port
//   res_valid, res_label, res_idx      neighbour label stream (one-cycle pulses)
//   busy, done, err                    status; err is the sticky watchdog flag
// Optional feature: define KNN_DRV_TIMEOUT_EN for the per-transaction watchdog.
module knn_bus_driver
  import knn_drv_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int LABEL       = 8,
  parameter int N_Neighbour = 4,
  parameter int A_RESET     = DEF_A_RESET,
  parameter int A_ENABLE    = DEF_A_ENABLE,
  parameter int A_A         = DEF_A_A,
  parameter int A_B         = DEF_A_B,
  parameter int A_LABEL     = DEF_A_LABEL,
  parameter int A_INFO0     = DEF_A_INFO0,
  parameter int TIMEOUT     = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [DATA_W-1:0]                  test_pt,
  input  logic                               tp_valid,
  output logic                               tp_ready,
  input  logic [DATA_W-1:0]                  tp_b,
  input  logic [LABEL-1:0]                   tp_label,
  input  logic                               tp_last,
  output logic                               m_valid,
  output logic [ADDR_W-1:0]                  m_address,
  output logic [DATA_W-1:0]                  m_wdata,
  output logic [DATA_W/8-1:0]                m_wstrb,
  input  logic [DATA_W-1:0]                  m_rdata,
  input  logic                               m_ready,
  output logic                               res_valid,
  output logic [LABEL-1:0]                   res_label,
  output logic [width_idx(N_Neighbour)-1:0]  res_idx,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int IW = width_idx(N_Neighbour);
  // One extra bit so the read counter can express "all reads issued".
  localparam int KW = IW + 1;
  localparam logic [KW-1:0] K_END = KW'(N_Neighbour);

  drv_state_t          state;
  logic [DATA_W-1:0]   test_q;
  logic [DATA_W-1:0]   b_q;
  logic [LABEL-1:0]    lbl_q;
  logic                last_q;
  logic [KW-1:0]       k;

  logic                req;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_we;
  logic                ack;
  logic                xact_timeout;
  logic [DATA_W-1:0]   rdata_q;

  // Request decode: each bus state presents one request until it is acked.
  always_comb begin
    req       = 1'b1;
    req_we    = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    case (state)
      S_RST_HI: begin req_addr = ADDR_W'(A_RESET);  req_wdata = DATA_W'(1); end
      S_RST_LO: begin req_addr = ADDR_W'(A_RESET);  req_wdata = '0;         end
      S_WR_EN:  begin req_addr = ADDR_W'(A_ENABLE); req_wdata = DATA_W'(1); end
      S_WR_A:   begin req_addr = ADDR_W'(A_A);      req_wdata = test_q;     end
      S_WR_B:   begin req_addr = ADDR_W'(A_B);      req_wdata = b_q;        end
      S_WR_LBL: begin req_addr = ADDR_W'(A_LABEL);  req_wdata = DATA_W'(lbl_q); end
      S_RD_INFO: begin
        req      = (k != K_END);
        req_we   = 1'b0;
        req_addr = ADDR_W'(A_INFO0) + ADDR_W'(k);
      end
      default: req = 1'b0;
    endcase
  end

  knn_drv_xact #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_xact (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .we        (req_we),
    .ack       (ack),
    .rdata_q   (rdata_q),
    .timeout   (xact_timeout),
    .m_valid   (m_valid),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  // The engine captures read data on completion, so it is already the
  // registered label in the res_valid cycle.
  assign res_label = rdata_q[LABEL-1:0];

  generate
    if (LABEL < DATA_W) begin : g_rd_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^rdata_q[DATA_W-1:LABEL];
    end
  endgenerate

`ifdef KNN_DRV_TIMEOUT_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_xact_timeout;
  assign unused_xact_timeout = xact_timeout;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      test_q    <= '0;
      b_q       <= '0;
      lbl_q     <= '0;
      last_q    <= 1'b0;
      k         <= '0;
      tp_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
`ifdef KNN_DRV_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      if (ack && (state == S_RD_INFO)) begin
        res_valid <= 1'b1;
        res_idx   <= k[IW-1:0];
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RST_HI;
            busy   <= 1'b1;
            test_q <= test_pt;
          end
        end
        S_RST_HI: if (ack) state <= S_RST_LO;
        S_RST_LO: if (ack) state <= S_WR_EN;
        S_WR_EN:  if (ack) state <= S_WR_A;
        S_WR_A: begin
          if (ack) begin
            state    <= S_WAIT_TP;
            tp_ready <= 1'b1;
          end
        end
        S_WAIT_TP: begin
          if (tp_valid && tp_ready) begin
            b_q      <= tp_b;
            lbl_q    <= tp_label;
            last_q   <= tp_last;
            tp_ready <= 1'b0;
            state    <= S_WR_B;
          end
        end
        S_WR_B: if (ack) state <= S_WR_LBL;
        S_WR_LBL: begin
          if (ack) begin
            if (last_q) begin
              state <= S_RD_INFO;
              k     <= '0;
            end else begin
              state    <= S_WAIT_TP;
              tp_ready <= 1'b1;
            end
          end
        end
        S_RD_INFO: begin
          // Linger one cycle after the final read so the last result is out
          // before DONE is entered.
          if (k == K_END) begin
            state <= S_DONE;
          end else if (ack) begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef KNN_DRV_TIMEOUT_EN
      // Abort overrides whatever the bus state intended this cycle.
      if (xact_timeout) begin
        state    <= S_DONE;
        tp_ready <= 1'b0;
        err_q    <= 1'b1;
      end else if ((state == S_IDLE) && start) begin
        err_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_knn_bus_driver.sv
// Self-checking bench for knn_bus_driver: table of runs against a transaction-list model.
// Latency: n/a (testbench).
// Backpressure: slave model with fixed or random m_ready latency; producer with stalls.
module tb_knn_bus_driver;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int LABEL  = 8;
  localparam int NN     = 4;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       test_pt = '0;
  logic              tp_valid = 1'b0;
  logic              tp_ready;
  logic [31:0]       tp_b = '0;
  logic [7:0]        tp_label = '0;
  logic              tp_last = 1'b0;
  logic              m_valid;
  logic [4:0]        m_address;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_rdata = '0;
  logic              m_ready = 1'b0;
  logic              res_valid;
  logic [7:0]        res_label;
  logic [1:0]        res_idx;
  logic              busy;
  logic              done;
  logic              err;

  knn_bus_driver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LABEL(LABEL), .N_Neighbour(NN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .test_pt(test_pt),
    .tp_valid(tp_valid), .tp_ready(tp_ready), .tp_b(tp_b), .tp_label(tp_label),
    .tp_last(tp_last), .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .res_valid(res_valid),
    .res_label(res_label), .res_idx(res_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } xact_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] lbl;
  } res_t;

  xact_t      got_x[$];
  xact_t      exp_x[$];
  logic [7:0] exp_lbl[$];
  res_t       got_r[$];

  // ---------------- slave model ----------------
  int         lat_max = 1;
  bit         spurious = 1'b0;
  bit         ignore_en = 1'b0;
  logic [4:0] ignore_addr = '0;
  bit         slv_act = 1'b0;
  int         slv_cnt = 0;

  always @(negedge clk) begin
    logic [31:0] rd;
    m_ready = 1'b0;
    if (!rst_n) begin
      slv_act = 1'b0;
    end else if (!slv_act) begin
      if (m_valid && !(ignore_en && m_address == ignore_addr)) begin
        slv_act = 1'b1;
        slv_cnt = (lat_max <= 1) ? 1 : $urandom_range(lat_max, 1);
      end else if (!m_valid && spurious && ($urandom_range(3, 0) == 0)) begin
        m_ready = 1'b1;
      end
    end else begin
      slv_cnt--;
      if (slv_cnt == 0) begin
        rd = $urandom;
        m_ready = 1'b1;
        m_rdata = rd;
        got_x.push_back({m_address, m_wdata, m_wstrb});
        if (m_wstrb == 4'h0) exp_lbl.push_back(rd[7:0]);
        slv_act = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int busy_cnt = 0, done_cnt = 0, done_cyc = 0, last_res_cyc = 0;
  int vhi = 0, last_streak = 0, lo_cnt = 0;
  int stab_viol = 0, gap_viol = 0, tpr_viol = 0;
  bit gap_arm = 1'b0, saw_tpr = 1'b0, pv = 1'b0;
  xact_t pp = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy) gap_arm = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (res_valid) begin
        got_r.push_back({res_idx, res_label});
        last_res_cyc = cyc;
      end
      if (m_valid && tp_ready) tpr_viol++;
      if (m_valid && pv && ({m_address, m_wdata, m_wstrb} !== pp)) stab_viol++;
      if (m_valid) begin
        if (!pv && gap_arm && !saw_tpr && lo_cnt != 1) gap_viol++;
        vhi++;
      end else begin
        if (pv) begin
          last_streak = vhi;
          gap_arm = 1'b1;
          lo_cnt = 0;
          saw_tpr = 1'b0;
        end
        vhi = 0;
        lo_cnt++;
        if (tp_ready) saw_tpr = 1'b1;
      end
      pv = m_valid;
      pp = {m_address, m_wdata, m_wstrb};
    end
  end

  // ---------------- run table ----------------
  typedef struct {
    logic [31:0] tpt;
    int          npts;
    int          stall;
    int          lat;
    bit          poke;
    bit          fixed;
    int          exp_xacts;
    int          exp_busy;   // 0: latency is random, not checked
  } vec_t;

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    if (!done) chk(name, 64'd0, 64'd1);
  endtask

  task automatic run(input vec_t v);
    logic [31:0] pb[$];
    logic [7:0]  pl[$];
    int x0, r0, l0, b0, d0, s0, g0, t0, nx, nr;
    exp_x.delete();
    for (int i = 0; i < v.npts; i++) begin
      pb.push_back((v.fixed && i == 0) ? 32'h10 : $urandom);
      pl.push_back((v.fixed && i == 0) ? 8'd3 : 8'($urandom_range(255, 0)));
    end
    // Model: the register program the peripheral must see, in order.
    exp_x.push_back({5'd0, 32'd1, 4'hF});
    exp_x.push_back({5'd0, 32'd0, 4'hF});
    exp_x.push_back({5'd1, 32'd1, 4'hF});
    exp_x.push_back({5'd2, v.tpt, 4'hF});
    for (int i = 0; i < v.npts; i++) begin
      exp_x.push_back({5'd3, pb[i], 4'hF});
      exp_x.push_back({5'd4, {24'd0, pl[i]}, 4'hF});
    end
    for (int i = 0; i < NN; i++) exp_x.push_back({5'(5 + i), 32'd0, 4'h0});

    x0 = got_x.size(); r0 = got_r.size(); l0 = exp_lbl.size();
    b0 = busy_cnt; d0 = done_cnt; s0 = stab_viol; g0 = gap_viol; t0 = tpr_viol;
    lat_max = v.lat;
    spurious = (v.lat > 1);

    @(negedge clk);
    start = 1'b1;
    test_pt = v.tpt;
    @(negedge clk);
    start = 1'b0;
    chk("err_cleared", {63'd0, err}, 64'd0);
    chk("busy_on", {63'd0, busy}, 64'd1);

    fork
      begin : producer
        for (int i = 0; i < v.npts; i++) begin
          int n = 0;
          while (!tp_ready && n < 2000) begin @(negedge clk); n++; end
          repeat (v.stall - 1) @(negedge clk);
          tp_valid = 1'b1;
          tp_b     = pb[i];
          tp_label = pl[i];
          tp_last  = (i == v.npts - 1);
          @(negedge clk);
          tp_valid = 1'b0;
        end
      end
      begin : poker
        if (v.poke) begin
          int n = 0;
          while (!(m_valid && m_address == 5'd5) && n < 3000) begin @(negedge clk); n++; end
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      wait_done("done_timeout");
    join
    repeat (5) @(negedge clk);

    nx = got_x.size() - x0;
    nr = got_r.size() - r0;
    chk("n_xacts", 64'(nx), 64'(v.exp_xacts));
    for (int i = 0; i < exp_x.size() && i < nx; i++) begin
      xact_t g, e;
      g = got_x[x0 + i];
      e = exp_x[i];
      chk("xact_addr", 64'(g.a), 64'(e.a));
      chk("xact_wstrb", 64'(g.s), 64'(e.s));
      if (e.s != 4'h0) chk("xact_wdata", 64'(g.d), 64'(e.d));
    end
    chk("n_results", 64'(nr), 64'(NN));
    for (int i = 0; i < nr && i < NN && (l0 + i) < exp_lbl.size(); i++) begin
      res_t g;
      g = got_r[r0 + i];
      chk("res_idx", 64'(g.idx), 64'(i));
      chk("res_label", 64'(g.lbl), 64'(exp_lbl[l0 + i]));
    end
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("done_after_last_res", 64'(done_cyc - last_res_cyc), 64'd2);
    if (v.exp_busy != 0) chk("busy_cycles", 64'(busy_cnt - b0), 64'(v.exp_busy));
    chk("payload_stable", 64'(stab_viol - s0), 64'd0);
    chk("one_cycle_gap", 64'(gap_viol - g0), 64'd0);
    chk("valid_vs_tp_ready", 64'(tpr_viol - t0), 64'd0);
    chk("idle_after_run", {63'd0, busy}, 64'd0);
    chk("err_after_run", {63'd0, err}, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h1234_5678, 1, 1, 1,  1'b0, 1'b1, 10, 33};
    vecs[1] = '{32'hCAFE_0001, 3, 5, 1,  1'b0, 1'b0, 14, 59};
    vecs[2] = '{32'h0000_0042, 2, 1, 10, 1'b0, 1'b0, 12, 0};
    vecs[3] = '{32'hFFFF_FFFF, 4, 2, 6,  1'b0, 1'b0, 16, 0};
    vecs[4] = '{32'hA5A5_5A5A, 1, 1, 1,  1'b1, 1'b0, 10, 33};
    vecs[5] = '{32'h0BAD_F00D, 5, 2, 1,  1'b0, 1'b0, 18, 66};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_m_valid",   {63'd0, m_valid}, 64'd0);
    chk("rst_m_address", 64'(m_address), 64'd0);
    chk("rst_m_wdata",   64'(m_wdata), 64'd0);
    chk("rst_m_wstrb",   64'(m_wstrb), 64'd0);
    chk("rst_tp_ready",  {63'd0, tp_ready}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_label", 64'(res_label), 64'd0);
    chk("rst_res_idx",   64'(res_idx), 64'd0);
    chk("rst_busy",      {63'd0, busy}, 64'd0);
    chk("rst_done",      {63'd0, done}, 64'd0);
    chk("rst_err",       {63'd0, err}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Reset asserted during the WR_B transaction, then a clean run.
    begin
      int n = 0;
      lat_max = 3;
      spurious = 1'b0;
      @(negedge clk);
      start = 1'b1;
      test_pt = 32'h7777_0000;
      @(negedge clk);
      start = 1'b0;
      while (!tp_ready && n < 500) begin @(negedge clk); n++; end
      tp_valid = 1'b1; tp_b = 32'h55; tp_label = 8'h9; tp_last = 1'b0;
      @(negedge clk);
      tp_valid = 1'b0;
      n = 0;
      while (!(m_valid && m_address == 5'd3) && n < 500) begin @(negedge clk); n++; end
      chk("reach_wr_b", {63'd0, m_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid",  {63'd0, m_valid}, 64'd0);
      chk("arst_m_address", 64'(m_address), 64'd0);
      chk("arst_m_wstrb",  64'(m_wstrb), 64'd0);
      chk("arst_busy",     {63'd0, busy}, 64'd0);
      chk("arst_tp_ready", {63'd0, tp_ready}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(vecs[0]);
    end

`ifdef KNN_DRV_TIMEOUT_EN
    // Slave never answers WR_EN: watchdog aborts the run.
    begin
      int r0, d0;
      r0 = got_r.size();
      d0 = done_cnt;
      lat_max = 1;
      spurious = 1'b0;
      ignore_en = 1'b1;
      ignore_addr = 5'd1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("to_done_timeout");
      repeat (4) @(negedge clk);
      chk("to_valid_cycles", 64'(last_streak), 64'(TO));
      chk("to_err",          {63'd0, err}, 64'd1);
      chk("to_no_results",   64'(got_r.size() - r0), 64'd0);
      chk("to_done_count",   64'(done_cnt - d0), 64'd1);
      chk("to_idle",         {63'd0, busy}, 64'd0);
      ignore_en = 1'b0;
      run(vecs[1]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
